// File: rtl/mips32_pkg.sv
// mips32_pkg: shared definitions for the pipelined MIPS32-subset core.
//   - opcode values (instruction bits [31:26])
//   - instruction class codes used by decode, hazard and forwarding logic
//   - run-control FSM states
//   - instruction field-slice helpers
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0A;
    localparam logic [5:0] OP_SUBI  = 6'h0B;
    localparam logic [5:0] OP_SLTI  = 6'h0C;
    localparam logic [5:0] OP_BNEQZ = 6'h0D;
    localparam logic [5:0] OP_BEQZ  = 6'h0E;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    typedef enum logic [2:0] {
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT
    } itype_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } run_state_t;

    function automatic logic [5:0] f_op(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] ir);
        return ir[15:0];
    endfunction

    // Unknown opcodes are classed as HALT so they stop the core.
    function automatic itype_t f_itype(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BNEQZ, OP_BEQZ:                             return BRANCH;
            default:                                       return HALT;
        endcase
    endfunction

endpackage

// File: rtl/mips32_regfile.sv
// mips32_regfile: 32 x XLEN register file.
//   clk, rst_n          clock, async active-low clear of all registers
//   we, waddr, wdata    single write port (writes to R0 discarded)
//   raddr1/rdata1,
//   raddr2/rdata2       async operand reads, write-through from the write port
//   dbg_raddr/dbg_rdata async debug read (plain array read)
// R0 always reads 0.
module mips32_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 != 5'd0) begin
            rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != 5'd0) begin
            rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
        end
    end

    always_comb begin
        dbg_rdata = '0;
        if (dbg_raddr != 5'd0) begin
            dbg_rdata = regs[dbg_raddr];
        end
    end

endmodule

// File: rtl/pipe_mips32_fwd.sv
// pipe_mips32_fwd: 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset core with
// forwarding, load-use interlock, branch flush and IDLE/RUN/HALTED control.
//   clk, rst_n               clock, async active-low reset
//   start                    IDLE/HALTED -> RUN from PC 0 (ignored in RUN)
//   prog_we/addr/wdata       program-load write, honoured only in IDLE
//   prog_rdata               combinational mem[prog_addr]
//   dbg_raddr/dbg_rdata      combinational register read (R0 = 0)
//   pc_out                   current fetch PC
//   alu_out                  registered EX/MEM ALU result
//   busy, halted             state == RUN, state == HALTED
//   retired, cycles          WB commits / RUN clocks since start
module pipe_mips32_fwd
    import mips32_pkg::*;
#(
    parameter int  XLEN      = 32,
    parameter int  MEM_DEPTH = 512,
    parameter bit  FWD_EN    = 1'b1,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [XLEN-1:0] prog_wdata,
    output logic [XLEN-1:0] prog_rdata,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [AW-1:0]   pc_out,
    output logic [XLEN-1:0] alu_out,
    output logic            busy,
    output logic            halted,
    output logic [31:0]     retired,
    output logic [31:0]     cycles
);

    run_state_t state, state_nxt;
    logic       launch, load_ok;

    logic [XLEN-1:0] mem [MEM_DEPTH];

    // IF
    logic [AW-1:0]   pc;
    logic [XLEN-1:0] if_word;
    logic            fetch_stop;

    // IF/ID and decode
    logic            ifid_valid;
    logic [31:0]     ifid_ir;
    logic [AW-1:0]   ifid_npc;
    logic [5:0]      id_op;
    logic [4:0]      id_rs, id_rt, id_dest;
    logic [XLEN-1:0] id_imm, rf_a, rf_b;
    itype_t          id_type;
    logic            id_use_rs, id_use_rt;

    // ID/EX
    logic            idex_valid;
    logic [5:0]      idex_op;
    itype_t          idex_type;
    logic [4:0]      idex_rs, idex_rt, idex_dest;
    logic [XLEN-1:0] idex_a, idex_b, idex_imm;
    logic [AW-1:0]   idex_npc;

    // EX
    logic [XLEN-1:0] ex_a, ex_b, ex_alu;
    logic            br_taken;
    logic [AW-1:0]   br_target;

    // EX/MEM
    logic            exmem_valid;
    itype_t          exmem_type;
    logic [4:0]      exmem_dest;
    logic [XLEN-1:0] exmem_alu, exmem_b, mem_rdata;

    // MEM/WB
    logic            memwb_valid;
    itype_t          memwb_type;
    logic [4:0]      memwb_dest;
    logic [XLEN-1:0] memwb_alu, memwb_lmd, wb_data;
    logic            wb_we, hlt_commit;

    logic            stall, hlt_in_id;

    function automatic logic src_hit(input logic [4:0] d, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rs,
                                     input logic use_rt);
        return (d != 5'd0) && ((use_rs && d == rs) || (use_rt && d == rt));
    endfunction

    // ---------------- run-control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start)      state_nxt = ST_RUN;
            ST_RUN:     if (hlt_commit) state_nxt = ST_HALTED;
            ST_HALTED:  if (start)      state_nxt = ST_RUN;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ST_RUN);
        halted  = (state == ST_HALTED);
        load_ok = (state == ST_IDLE);
        launch  = start && (state != ST_RUN);
    end

    // ---------------- memory ----------------
    assign if_word    = mem[pc];
    assign mem_rdata  = mem[exmem_alu[AW-1:0]];
    assign prog_rdata = mem[prog_addr];

    // Reads above are combinational, so an IF read coinciding with a MEM
    // write to the same word sees the old contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (load_ok && prog_we) begin
                mem[prog_addr] <= prog_wdata;
            end else if (busy && exmem_valid && exmem_type == STORE) begin
                mem[exmem_alu[AW-1:0]] <= exmem_b;
            end
        end
    end

    // ---------------- decode ----------------
    always_comb begin
        id_op     = f_op(ifid_ir);
        id_rs     = f_rs(ifid_ir);
        id_rt     = f_rt(ifid_ir);
        id_imm    = {{(XLEN-16){ifid_ir[15]}}, f_imm(ifid_ir)};
        id_type   = f_itype(id_op);
        id_use_rs = (id_type != HALT);
        id_use_rt = (id_type == RR_ALU) || (id_type == STORE);
        id_dest   = '0;
        if (id_type == RR_ALU)                          id_dest = f_rd(ifid_ir);
        else if (id_type == RM_ALU || id_type == LOAD)  id_dest = id_rt;
    end

    assign wb_data    = (memwb_type == LOAD) ? memwb_lmd : memwb_alu;
    assign wb_we      = busy && memwb_valid && memwb_dest != 5'd0;
    assign hlt_commit = memwb_valid && memwb_type == HALT;

    mips32_regfile #(.XLEN(XLEN)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (wb_we),
        .waddr     (memwb_dest),
        .wdata     (wb_data),
        .raddr1    (id_rs),
        .rdata1    (rf_a),
        .raddr2    (id_rt),
        .rdata2    (rf_b),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    // ---------------- hazards ----------------
    // With forwarding only a load directly ahead needs a bubble; without it,
    // ID waits until no in-flight producer of a source register remains.
    always_comb begin
        stall = 1'b0;
        if (ifid_valid) begin
            if (FWD_EN) begin
                stall = idex_valid && idex_type == LOAD &&
                        src_hit(idex_dest, id_rs, id_rt, id_use_rs, id_use_rt);
            end else begin
                stall = (idex_valid  && src_hit(idex_dest,  id_rs, id_rt, id_use_rs, id_use_rt)) ||
                        (exmem_valid && src_hit(exmem_dest, id_rs, id_rt, id_use_rs, id_use_rt)) ||
                        (memwb_valid && src_hit(memwb_dest, id_rs, id_rt, id_use_rs, id_use_rt));
            end
        end
    end

    assign hlt_in_id = ifid_valid && id_type == HALT;

    // ---------------- execute ----------------
    always_comb begin
        ex_a = idex_a;
        ex_b = idex_b;
        if (FWD_EN) begin
            if (exmem_valid && exmem_type != LOAD && exmem_dest != 5'd0 && exmem_dest == idex_rs)
                ex_a = exmem_alu;
            else if (memwb_valid && memwb_dest != 5'd0 && memwb_dest == idex_rs)
                ex_a = wb_data;
            if (exmem_valid && exmem_type != LOAD && exmem_dest != 5'd0 && exmem_dest == idex_rt)
                ex_b = exmem_alu;
            else if (memwb_valid && memwb_dest != 5'd0 && memwb_dest == idex_rt)
                ex_b = wb_data;
        end
    end

    always_comb begin
        case (idex_op)
            OP_ADD:  ex_alu = ex_a + ex_b;
            OP_SUB:  ex_alu = ex_a - ex_b;
            OP_AND:  ex_alu = ex_a & ex_b;
            OP_OR:   ex_alu = ex_a | ex_b;
            OP_SLT:  ex_alu = {{(XLEN-1){1'b0}}, ex_a < ex_b};
            OP_MUL:  ex_alu = ex_a * ex_b;
            OP_SUBI: ex_alu = ex_a - idex_imm;
            OP_SLTI: ex_alu = {{(XLEN-1){1'b0}}, ex_a < idex_imm};
            default: ex_alu = ex_a + idex_imm;
        endcase
    end

    assign br_taken  = idex_valid && idex_type == BRANCH &&
                       ((idex_op == OP_BEQZ) == (ex_a == '0));
    assign br_target = idex_npc + idex_imm[AW-1:0];

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            fetch_stop  <= 1'b0;
            ifid_valid  <= 1'b0;
            ifid_ir     <= '0;
            ifid_npc    <= '0;
            idex_valid  <= 1'b0;
            idex_op     <= '0;
            idex_type   <= HALT;
            idex_rs     <= '0;
            idex_rt     <= '0;
            idex_dest   <= '0;
            idex_a      <= '0;
            idex_b      <= '0;
            idex_imm    <= '0;
            idex_npc    <= '0;
            exmem_valid <= 1'b0;
            exmem_type  <= HALT;
            exmem_dest  <= '0;
            exmem_alu   <= '0;
            exmem_b     <= '0;
            memwb_valid <= 1'b0;
            memwb_type  <= HALT;
            memwb_dest  <= '0;
            memwb_alu   <= '0;
            memwb_lmd   <= '0;
            retired     <= '0;
            cycles      <= '0;
        end else if (launch) begin
            pc          <= '0;
            fetch_stop  <= 1'b0;
            ifid_valid  <= 1'b0;
            idex_valid  <= 1'b0;
            exmem_valid <= 1'b0;
            memwb_valid <= 1'b0;
            retired     <= '0;
            cycles      <= '0;
        end else if (busy) begin
            cycles <= cycles + 32'd1;
            if (memwb_valid) retired <= retired + 32'd1;

            // A taken branch overrides everything; a decoded HLT freezes
            // fetch for good and discards whatever is behind it.
            if (br_taken) begin
                pc         <= br_target;
                ifid_valid <= 1'b0;
            end else if (!stall) begin
                if (hlt_in_id || fetch_stop) begin
                    ifid_valid <= 1'b0;
                end else begin
                    pc         <= pc + 1'b1;
                    ifid_valid <= 1'b1;
                    ifid_ir    <= if_word[31:0];
                    ifid_npc   <= pc + 1'b1;
                end
            end
            if (hlt_in_id && !br_taken) fetch_stop <= 1'b1;

            idex_valid <= ifid_valid && !stall && !br_taken;
            idex_op    <= id_op;
            idex_type  <= id_type;
            idex_rs    <= id_rs;
            idex_rt    <= id_rt;
            idex_dest  <= id_dest;
            idex_a     <= rf_a;
            idex_b     <= rf_b;
            idex_imm   <= id_imm;
            idex_npc   <= ifid_npc;

            exmem_valid <= idex_valid;
            exmem_type  <= idex_type;
            exmem_dest  <= idex_dest;
            exmem_alu   <= ex_alu;
            exmem_b     <= ex_b;

            memwb_valid <= exmem_valid;
            memwb_type  <= exmem_type;
            memwb_dest  <= exmem_dest;
            memwb_alu   <= exmem_alu;
            memwb_lmd   <= mem_rdata;
        end
    end

    assign pc_out  = pc;
    assign alu_out = exmem_alu;

endmodule

// File: tb/tb_pipe_mips32_fwd.sv
module tb_pipe_mips32_fwd;

    localparam logic [5:0] ADD = 6'h00, LW = 6'h08, SW = 6'h09, ADDI = 6'h0A,
                           BNEQZ = 6'h0D, BEQZ = 6'h0E, HLT = 6'h3F;

    logic        clk = 1'b0;
    logic        rst_n, start, prog_we;
    logic [8:0]  prog_addr;
    logic [31:0] prog_wdata;
    logic [4:0]  dbg_raddr;

    logic [31:0] prog_rdata, dbg_rdata, alu_out, retired, cycles;
    logic [8:0]  pc_out;
    logic        busy, halted;

    logic [31:0] prog_rdata_nf, dbg_rdata_nf, alu_out_nf, retired_nf, cycles_nf;
    logic [8:0]  pc_out_nf;
    logic        busy_nf, halted_nf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_mips32_fwd #(.XLEN(32), .MEM_DEPTH(512), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_rdata(prog_rdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc_out(pc_out),
        .alu_out(alu_out), .busy(busy), .halted(halted),
        .retired(retired), .cycles(cycles)
    );

    pipe_mips32_fwd #(.XLEN(32), .MEM_DEPTH(512), .FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_rdata(prog_rdata_nf),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata_nf), .pc_out(pc_out_nf),
        .alu_out(alu_out_nf), .busy(busy_nf), .halted(halted_nf),
        .retired(retired_nf), .cycles(cycles_nf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'b0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic put(input logic [8:0] a, input logic [31:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!(halted && halted_nf) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'b0, halted && halted_nf}, 32'd1);
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        dbg_raddr = r;
        #1;
        check_eq(tag, dbg_rdata, exp);
    endtask

    task automatic chk_reg_nf(input string tag, input logic [4:0] r, input logic [31:0] exp);
        dbg_raddr = r;
        #1;
        check_eq(tag, dbg_rdata_nf, exp);
    endtask

    task automatic chk_mem(input string tag, input logic [8:0] a, input logic [31:0] exp);
        prog_addr = a;
        #1;
        check_eq(tag, prog_rdata, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_wdata = '0; dbg_raddr = '0;
        @(negedge clk);
        #1;
        check_eq("rst_busy",    {31'b0, busy}, 32'd0);
        check_eq("rst_halted",  {31'b0, halted}, 32'd0);
        check_eq("rst_pc",      {23'b0, pc_out}, 32'd0);
        check_eq("rst_alu",     alu_out, 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_cycles",  cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: RAW chain
        do_reset();
        put(0, enc_i(ADDI, 0, 1, 16'd10));
        put(1, enc_r(ADD, 1, 1, 2));
        put(2, enc_r(ADD, 2, 1, 3));
        put(3, {HLT, 26'b0});
        go();
        wait_halt("t1_halt");
        chk_reg("t1_r2", 2, 32'd20);
        chk_reg("t1_r3", 3, 32'd30);
        check_eq("t1_retired", retired, 32'd4);
        check_eq("t1_cycles", cycles, 32'd8);
        chk_reg_nf("t1_nf_r2", 2, 32'd20);
        chk_reg_nf("t1_nf_r3", 3, 32'd30);
        check_eq("t1_nf_retired", retired_nf, 32'd4);
        check_eq("t1_nf_slower", {31'b0, cycles_nf > cycles}, 32'd1);

        // 2: load-use, one bubble over the 9-cycle hazard-free count
        do_reset();
        put(0, enc_i(ADDI, 0, 1, 16'd7));
        put(1, enc_i(SW, 0, 1, 16'd100));
        put(2, enc_i(LW, 0, 2, 16'd100));
        put(3, enc_r(ADD, 2, 2, 3));
        put(4, {HLT, 26'b0});
        go();
        wait_halt("t2_halt");
        chk_mem("t2_mem100", 9'd100, 32'd7);
        chk_reg("t2_r3", 3, 32'd14);
        check_eq("t2_cycles", cycles, 32'd10);
        check_eq("t2_retired", retired, 32'd5);
        chk_reg_nf("t2_nf_r3", 3, 32'd14);

        // 3: branch shadow
        do_reset();
        put(200, 32'h55);
        put(0, enc_i(BEQZ, 0, 0, 16'd2));
        put(1, enc_i(ADDI, 0, 5, 16'd1));
        put(2, enc_i(SW, 0, 0, 16'd200));
        put(3, enc_i(ADDI, 0, 6, 16'd3));
        put(4, {HLT, 26'b0});
        go();
        wait_halt("t3_halt");
        chk_reg("t3_r5", 5, 32'd0);
        chk_reg("t3_r6", 6, 32'd3);
        chk_mem("t3_mem200", 9'd200, 32'h55);
        check_eq("t3_retired", retired, 32'd3);
        check_eq("t3_cycles", cycles, 32'd9);

        // 4: halt, write-protect in HALTED, restart
        do_reset();
        put(0, enc_i(ADDI, 0, 1, 16'd1));
        put(1, {HLT, 26'b0});
        put(2, enc_i(ADDI, 0, 2, 16'd9));
        go();
        wait_halt("t4_halt");
        check_eq("t4_halted", {31'b0, halted}, 32'd1);
        check_eq("t4_busy", {31'b0, busy}, 32'd0);
        chk_reg("t4_r1", 1, 32'd1);
        chk_reg("t4_r2", 2, 32'd0);
        check_eq("t4_retired", retired, 32'd2);
        check_eq("t4_cycles", cycles, 32'd6);
        put(2, 32'hDEAD);
        chk_mem("t4_prog_we_dropped", 9'd2, enc_i(ADDI, 0, 2, 16'd9));
        go();
        check_eq("t4_restart_busy", {31'b0, busy}, 32'd1);
        check_eq("t4_restart_pc", {23'b0, pc_out}, 32'd0);
        check_eq("t4_restart_retired", retired, 32'd0);
        check_eq("t4_restart_cycles", cycles, 32'd0);
        wait_halt("t4_halt2");
        check_eq("t4_retired2", retired, 32'd2);
        chk_reg("t4_r1_again", 1, 32'd1);

        // 5: address wrap on load and on branch target
        do_reset();
        put(511, 32'h1234);
        put(0, enc_i(BNEQZ, 1, 0, 16'd4));
        put(1, enc_i(LW, 0, 1, 16'hFFFF));
        put(2, enc_i(BNEQZ, 1, 0, 16'd509));
        put(3, enc_i(ADDI, 0, 7, 16'd1));
        put(4, enc_i(ADDI, 0, 7, 16'd1));
        put(5, enc_i(ADDI, 0, 6, 16'd6));
        put(6, {HLT, 26'b0});
        go();
        wait_halt("t5_halt");
        chk_reg("t5_r1", 1, 32'h1234);
        chk_reg("t5_r6", 6, 32'd6);
        chk_reg("t5_r7", 7, 32'd0);
        check_eq("t5_retired", retired, 32'd6);
        chk_reg_nf("t5_nf_r6", 6, 32'd6);

        // 6: reset while SW is in EX
        do_reset();
        put(300, 32'h11);
        put(0, enc_i(ADDI, 0, 1, 16'h77));
        put(1, enc_i(SW, 0, 1, 16'd300));
        put(2, {HLT, 26'b0});
        go();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_alu_before", alu_out, 32'h77);
        rst_n = 1'b0;
        #1;
        check_eq("t6_busy", {31'b0, busy}, 32'd0);
        check_eq("t6_halted", {31'b0, halted}, 32'd0);
        check_eq("t6_pc", {23'b0, pc_out}, 32'd0);
        check_eq("t6_alu", alu_out, 32'd0);
        check_eq("t6_retired", retired, 32'd0);
        check_eq("t6_cycles", cycles, 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_mem("t6_store_aborted", 9'd300, 32'h11);
        chk_reg("t6_r1", 1, 32'd0);
        put(300, 32'hAB);
        chk_mem("t6_idle_prog_we", 9'd300, 32'hAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
